ase_pcie_ss_tx_pkt_fifo: RTL
============================

ASE_PCIE_SS_TX_PKT_FIFO -- requirements
Module: ase_pcie_ss_tx_pkt_fifo

Purpose: buffering stage on the AFU->host TLP stream, directly upstream of the PCIe SS emulator TX sink; absorbs emulator tready stalls and optionally releases only whole packets.

Interface
REQ-001 Parameter DEPTH, default 16, entries of beat storage; power of 2, >= 4.
REQ-002 Parameter STORE_AND_FORWARD, default 0; 1 = no beat of a packet leaves until its tlast beat is stored.
REQ-003 Port clk  input  1  sole clock; all logic on posedge.
REQ-004 Port SoftReset  input  1  synchronous, active-high reset.
REQ-005 Port afu_tx_if  pcie_ss_axis_if.sink  -  TLP stream from AFU (tvalid, tready, tdata, tkeep, tlast, tuser_vendor).
REQ-006 Port host_tx_if  pcie_ss_axis_if.source  -  TLP stream to emulator TX sink.
REQ-007 Port occupancy  output  $clog2(DEPTH)+1  beats currently stored.
REQ-008 Port pkt_count  output  $clog2(DEPTH)+1  complete packets (tlast stored) currently held.
REQ-009 Port err_long_pkt  output  1  sticky: SAF deadlock escape taken.
REQ-010 Port err_null_keep  output  1  sticky: beat accepted with tkeep == 0.

Function
REQ-011 afu_tx_if.tready = (occupancy < DEPTH) && !SoftReset; registered; no combinational path from host_tx_if.tready.
REQ-012 Push on afu_tx_if.tvalid && tready; entry stores tdata, tkeep, tlast, tuser_vendor unmodified.
REQ-013 Pop on host_tx_if.tvalid && host_tx_if.tready; host_tx_if outputs present head entry, held stable while tvalid && !tready.
REQ-014 Latency: beat pushed in cycle N is eligible on host_tx_if no earlier than cycle N+1; throughput 1 beat/cycle sustained.
REQ-015 STORE_AND_FORWARD=0: host_tx_if.tvalid = (occupancy != 0).
REQ-016 STORE_AND_FORWARD=1: host_tx_if.tvalid = (pkt_count != 0) || draining; draining set on pop of a non-tlast beat, cleared on pop of tlast beat, so a started packet always completes.
REQ-017 SAF deadlock escape: occupancy == DEPTH and pkt_count == 0 -> forward as cut-through until next tlast pop; set err_long_pkt.
REQ-018 occupancy: +1 push, -1 pop, unchanged on simultaneous push+pop; never exceeds DEPTH nor underflows.
REQ-019 pkt_count: +1 on push with tlast, -1 on pop with tlast, unchanged when both.
REQ-020 Pointers wrap modulo DEPTH; full/empty distinguished by occupancy, not pointer equality.
REQ-021 Push when full is impossible (tready low); push and pop in same cycle when full: pop occurs, tready rises next cycle.
REQ-022 err_null_keep set on push with tkeep == '0; both sticky flags cleared only by reset.

Reset
REQ-023 While SoftReset: afu_tx_if.tready=0, host_tx_if.tvalid=0, tlast=0, tdata/tkeep/tuser_vendor='0, occupancy=0, pkt_count=0, draining=0, sticky flags=0.
REQ-024 Reset mid-packet discards all stored beats, including partial packets; first cycle after deassertion tready=1, tvalid=0.
REQ-025 Storage array contents need not be reset.

Structure
REQ-026 Entry struct t_ase_pcie_ss_tx_fifo_entry (tdata, tkeep, tlast, tuser_vendor) lives in ase_pcie_ss_pkg, widths from ofs_pcie_ss_cfg_pkg.
REQ-027 Storage in sub-module ase_pcie_ss_fifo_ram (DEPTH x entry, 1 write port, 1 read port); control, counters, SAF logic in top.

Verification
REQ-028 Single 1-beat packet, host_tx_if.tready=1, SAF=0 -> beat on output cycle N+1, occupancy returns to 0, pkt_count 1->0.
REQ-029 SAF=1, 4-beat packet with 2-cycle gap before tlast -> host_tx_if.tvalid stays 0 until tlast stored, then 4 consecutive beats.
REQ-030 DEPTH=16, host tready=0, 20 beats offered -> exactly 16 accepted, tready low; one pop -> tready high next cycle, occupancy 16->15->16.
REQ-031 SAF=1, 17-beat packet with DEPTH=16 -> escape taken, err_long_pkt=1, all 17 beats delivered in order.
REQ-032 SoftReset asserted with 3 beats of partial packet stored -> outputs per REQ-023, after release new packet delivered with no stale beats.
REQ-033 Beat with tkeep=0 pushed -> err_null_keep=1 and remains 1 until reset; data still forwarded.

Source files
------------

// File: rtl/ase_pcie_ss_tx_pkt_fifo_pkg.sv
// Stream widths for the PCIe SS emulator TX path and the stored FIFO entry layout.
package ofs_pcie_ss_cfg_pkg;
   localparam int TDATA_WIDTH        = 64;
   localparam int TKEEP_WIDTH        = TDATA_WIDTH / 8;
   localparam int TUSER_VENDOR_WIDTH = 10;
endpackage

package ase_pcie_ss_pkg;
   import ofs_pcie_ss_cfg_pkg::*;

   typedef struct packed {
      logic [TDATA_WIDTH-1:0]        tdata;
      logic [TKEEP_WIDTH-1:0]        tkeep;
      logic                          tlast;
      logic [TUSER_VENDOR_WIDTH-1:0] tuser_vendor;
   } t_ase_pcie_ss_tx_fifo_entry;
endpackage

// File: rtl/ase_pcie_ss_tx_pkt_fifo_if.sv
// AXI-Stream TLP bus between AFU, TX packet FIFO and emulator sink.
interface pcie_ss_axis_if;
   import ofs_pcie_ss_cfg_pkg::*;

   logic                          tvalid;
   logic                          tready;
   logic [TDATA_WIDTH-1:0]        tdata;
   logic [TKEEP_WIDTH-1:0]        tkeep;
   logic                          tlast;
   logic [TUSER_VENDOR_WIDTH-1:0] tuser_vendor;

   modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
   modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ase_pcie_ss_tx_pkt_fifo_ram.sv
// Beat storage: one write port, asynchronous read of the head entry; contents are never reset.
module ase_pcie_ss_fifo_ram
   import ase_pcie_ss_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  t_ase_pcie_ss_tx_fifo_entry wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output t_ase_pcie_ss_tx_fifo_entry rdata_o
);
   t_ase_pcie_ss_tx_fifo_entry mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ase_pcie_ss_tx_pkt_fifo.sv
// AFU->host TLP buffer that absorbs sink stalls and can hold packets until their tlast is stored.
module ase_pcie_ss_tx_pkt_fifo
   import ase_pcie_ss_pkg::*;
#(
   parameter int DEPTH             = 16,
   parameter bit STORE_AND_FORWARD = 1'b0
) (
   input  logic                     clk,
   input  logic                     SoftReset,
   pcie_ss_axis_if.sink             afu_tx_if,
   pcie_ss_axis_if.source           host_tx_if,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [$clog2(DEPTH):0]   pkt_count,
   output logic                     err_long_pkt,
   output logic                     err_null_keep
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d, pkt_q, pkt_d;
   logic          tready_q, tready_d;
   logic          draining_q, draining_d;
   logic          err_long_q, err_long_d, err_null_q, err_null_d;
   logic          tready, tvalid, push, pop, push_last, pop_last, esc_now;
   t_ase_pcie_ss_tx_fifo_entry wr_entry, head;

   assign wr_entry.tdata        = afu_tx_if.tdata;
   assign wr_entry.tkeep        = afu_tx_if.tkeep;
   assign wr_entry.tlast        = afu_tx_if.tlast;
   assign wr_entry.tuser_vendor = afu_tx_if.tuser_vendor;

   ase_pcie_ss_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // tready comes from a flop so the sink's tready never reaches the AFU combinationally.
   assign tready    = tready_q && !SoftReset;
   assign push      = afu_tx_if.tvalid && tready;
   assign pop       = tvalid && host_tx_if.tready;
   assign push_last = push && afu_tx_if.tlast;
   assign pop_last  = pop && head.tlast;

   // A full FIFO with no complete packet can never release one: fall back to cut-through.
   assign esc_now = STORE_AND_FORWARD && (occ_q == FULL) && (pkt_q == '0);

   always_comb begin
      tvalid = (occ_q != '0);
      if (STORE_AND_FORWARD) tvalid = tvalid && ((pkt_q != '0) || draining_q || esc_now);
      if (SoftReset) tvalid = 1'b0;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      pkt_d      = pkt_q;
      draining_d = draining_q;
      err_long_d = err_long_q;
      err_null_d = err_null_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + CW'(1);
      else if (!push && pop) occ_d = occ_q - CW'(1);
      if (push_last && !pop_last)      pkt_d = pkt_q + CW'(1);
      else if (!push_last && pop_last) pkt_d = pkt_q - CW'(1);
      if (pop) draining_d = !head.tlast;
      if (esc_now) err_long_d = 1'b1;
      if (push && (afu_tx_if.tkeep == '0)) err_null_d = 1'b1;
      tready_d = (occ_d < FULL);
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         pkt_q      <= '0;
         tready_q   <= 1'b1;
         draining_q <= 1'b0;
         err_long_q <= 1'b0;
         err_null_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         pkt_q      <= pkt_d;
         tready_q   <= tready_d;
         draining_q <= draining_d;
         err_long_q <= err_long_d;
         err_null_q <= err_null_d;
      end
   end

   assign afu_tx_if.tready        = tready;
   assign host_tx_if.tvalid       = tvalid;
   assign host_tx_if.tdata        = tvalid ? head.tdata : '0;
   assign host_tx_if.tkeep        = tvalid ? head.tkeep : '0;
   assign host_tx_if.tlast        = tvalid && head.tlast;
   assign host_tx_if.tuser_vendor = tvalid ? head.tuser_vendor : '0;

   assign occupancy     = SoftReset ? '0 : occ_q;
   assign pkt_count     = SoftReset ? '0 : pkt_q;
   assign err_long_pkt  = err_long_q && !SoftReset;
   assign err_null_keep = err_null_q && !SoftReset;
endmodule
